bcd_mod_counter: RTL and testbench
==================================

# bcd_mod_counter

Parametrised two-digit BCD counter with seven-segment drivers, the general successor to the fixed 0–59 clock stage. It counts MIN_VAL..MAX_VAL on a tick input and raises a same-cycle carry for chaining into the next stage. In set mode it accepts increment and decrement pulses and blinks its display. One instance per seconds, minutes or hours field of the clock chain.

## Interface
Parameters:
- MIN_VAL, 0, lowest count value (0..98)
- MAX_VAL, 59, highest count value (MIN_VAL+1..99)
- BLINK_PERIOD, 50_000_000, set-mode blink period in clk cycles (even, ≥2)
- ZERO_BLANK, 0, 1 = blank the tens digit when it is 0

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  synchronous, active-low reset
- tick  in  1  count-enable pulse from the previous stage or the time base
- modify  in  1  1 = set mode, 0 = run mode (level)
- inc  in  1  set-mode increment pulse (debounced, one cycle)
- dec  in  1  set-mode decrement pulse (debounced, one cycle)
- cout  out  1  carry to the next stage, combinational
- ones  out  4  BCD ones digit
- tens  out  4  BCD tens digit
- display0  out  8  ones segments, active-low, {a..g,dp}
- display1  out  8  tens segments, active-low, {a..g,dp}

## Operation
- State: ones/tens BCD registers, blink counter of $clog2(BLINK_PERIOD) bits, and the registered copy modify_q.
- Run mode (modify=0):
  - tick=1 increments the value.
  - At MAX_VAL, tick=1 loads MIN_VAL.
  - inc and dec are ignored.
- Set mode (modify=1):
  - tick is ignored.
  - inc alone increments, wrapping MAX_VAL→MIN_VAL.
  - dec alone decrements, wrapping MIN_VAL→MAX_VAL.
  - inc and dec together leave the value unchanged.
- Increment: ones 9→0 with tens+1. Decrement: ones 0→9 with tens−1. Digits never hold a non-BCD value.
- cout = tick & ~modify & (value==MAX_VAL) & rst. Set-mode wraps never assert cout.
- Segment encoding for both display outputs:
  - 0:03, 1:9f, 2:25, 3:0d, 4:99
  - 5:49, 6:41, 7:1f, 8:01, 9:09
  - anything else: ff
- ZERO_BLANK=1: display1=ff whenever tens==0.
- Blink:
  - In set mode, the counter runs 0..BLINK_PERIOD−1 and wraps.
  - Both displays read ff while the counter ≥ BLINK_PERIOD/2.
  - Entering set mode (modify=1 & modify_q=0) clears the counter, so the first half-period is visible.
  - In run mode the counter is held at 0 and the displays are never blanked.

## Timing
- Reset (rst=0 at an edge):
  - ones/tens = digits of MIN_VAL.
  - Blink counter = 0, modify_q = 0.
  - cout = 0 while rst=0.
  - display0/display1 decode MIN_VAL.
- Reset mid-operation overrides tick, inc and dec in the same cycle.
- Latency:
  - A tick, inc or dec sampled at edge N produces the new ones/tens/display values after edge N.
  - cout is valid in the same cycle as tick, before edge N, so a chained stage advances on the same edge.
- Displays are combinational from the registered digits and the blink counter; there is no extra register stage.
- Mode changes take effect on the first edge sampling the new modify level.
- A tick arriving in the same cycle that modify rises is ignored.
- Back-to-back ticks on consecutive cycles each advance by one; there is no rate limit.

## Test plan
- Reset, then 60 ticks with defaults: value steps 00..59→00; cout high only in the cycle tick is applied at 59; display0=03, display1=03 afterwards.
- MIN_VAL=1, MAX_VAL=12, ZERO_BLANK=1: reset shows ones=1, display1=ff; 12 ticks end at 01 with one cout pulse; the value at 12 shows display1=9f, display0=25.
- Set mode at 00 (defaults), one dec: value becomes 59 with cout=0; one inc returns to 00; inc+dec together: value unchanged; ticks during set mode: value unchanged, cout=0.
- BLINK_PERIOD=8: raise modify; displays are visible for 4 cycles, then ff for 4, repeating; drop and re-raise modify mid-blank: visible again immediately after the edge.
- Assert rst during set mode at value 37 with tick and inc high: next state is MIN_VAL; cout=0 throughout reset.
- Chain two instances (0–59 into 0–23): 1440 ticks to the first stage wrap the second from 23→00 exactly once; no intermediate non-BCD digit is observed.

Source files
------------

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter over MIN_VAL..MAX_VAL with same-cycle carry, set-mode
// inc/dec editing and a blinking active-low seven-segment display pair.
module bcd_mod_counter #(
    parameter int unsigned MIN_VAL      = 0,
    parameter int unsigned MAX_VAL      = 59,
    parameter int unsigned BLINK_PERIOD = 50_000_000,
    parameter int unsigned ZERO_BLANK   = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       modify,
    input  logic       inc,
    input  logic       dec,
    output logic       cout,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic [7:0] display0,
    output logic [7:0] display1
);

    localparam int unsigned BW   = $clog2(BLINK_PERIOD);
    localparam int unsigned Half = BLINK_PERIOD / 2;

    localparam logic [3:0] MinOnes = 4'(MIN_VAL % 10);
    localparam logic [3:0] MinTens = 4'(MIN_VAL / 10);
    localparam logic [3:0] MaxOnes = 4'(MAX_VAL % 10);
    localparam logic [3:0] MaxTens = 4'(MAX_VAL / 10);

    logic [3:0]    ones_q, ones_d;
    logic [3:0]    tens_q, tens_d;
    logic [BW-1:0] blink_q, blink_d;
    logic          modify_q;

    logic at_max, at_min, do_inc, do_dec, blank;

    function automatic logic [7:0] seg7(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'h03;
            4'd1:    s = 8'h9f;
            4'd2:    s = 8'h25;
            4'd3:    s = 8'h0d;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h49;
            4'd6:    s = 8'h41;
            4'd7:    s = 8'h1f;
            4'd8:    s = 8'h01;
            4'd9:    s = 8'h09;
            default: s = 8'hff;
        endcase
        return s;
    endfunction

    assign at_max = (tens_q == MaxTens) && (ones_q == MaxOnes);
    assign at_min = (tens_q == MinTens) && (ones_q == MinOnes);

    // Set mode edits with inc/dec only; run mode advances on tick only.
    assign do_inc = modify ? (inc & ~dec) : tick;
    assign do_dec = modify & dec & ~inc;

    always_comb begin
        ones_d = ones_q;
        tens_d = tens_q;
        if (do_inc) begin
            if (at_max) begin
                ones_d = MinOnes;
                tens_d = MinTens;
            end else if (ones_q == 4'd9) begin
                ones_d = 4'd0;
                tens_d = tens_q + 4'd1;
            end else begin
                ones_d = ones_q + 4'd1;
            end
        end else if (do_dec) begin
            if (at_min) begin
                ones_d = MaxOnes;
                tens_d = MaxTens;
            end else if (ones_q == 4'd0) begin
                ones_d = 4'd9;
                tens_d = tens_q - 4'd1;
            end else begin
                ones_d = ones_q - 4'd1;
            end
        end
    end

    // Held at zero in run mode and restarted on entry so the first half is visible.
    always_comb begin
        blink_d = '0;
        if (modify && modify_q) begin
            if (blink_q != BW'(BLINK_PERIOD - 1)) begin
                blink_d = blink_q + BW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ones_q   <= MinOnes;
            tens_q   <= MinTens;
            blink_q  <= '0;
            modify_q <= 1'b0;
        end else begin
            ones_q   <= ones_d;
            tens_q   <= tens_d;
            blink_q  <= blink_d;
            modify_q <= modify;
        end
    end

    assign blank = (blink_q >= BW'(Half));
    assign cout  = tick & ~modify & at_max & rst;
    assign ones  = ones_q;
    assign tens  = tens_q;

    always_comb begin
        display0 = seg7(ones_q);
        display1 = seg7(tens_q);
        if ((ZERO_BLANK != 0) && (tens_q == 4'd0)) begin
            display1 = 8'hff;
        end
        if (blank) begin
            display0 = 8'hff;
            display1 = 8'hff;
        end
    end

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Bench for bcd_mod_counter: three instances (default 0-59, 1-12 blanked, 0-23
// chained off the first) checked every cycle against an arithmetic model.
module tb_bcd_mod_counter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic tick = 1'b0;
    logic modify = 1'b0;
    logic inc = 1'b0;
    logic dec = 1'b0;

    logic       cout_w [3];
    logic [3:0] ones_w [3];
    logic [3:0] tens_w [3];
    logic [7:0] d0_w   [3];
    logic [7:0] d1_w   [3];

    always #5 clk = ~clk;

    bcd_mod_counter u_a (
        .clk(clk), .rst(rst), .tick(tick), .modify(modify), .inc(inc), .dec(dec),
        .cout(cout_w[0]), .ones(ones_w[0]), .tens(tens_w[0]),
        .display0(d0_w[0]), .display1(d1_w[0])
    );

    bcd_mod_counter #(
        .MIN_VAL(1), .MAX_VAL(12), .BLINK_PERIOD(8), .ZERO_BLANK(1)
    ) u_b (
        .clk(clk), .rst(rst), .tick(tick), .modify(modify), .inc(inc), .dec(dec),
        .cout(cout_w[1]), .ones(ones_w[1]), .tens(tens_w[1]),
        .display0(d0_w[1]), .display1(d1_w[1])
    );

    bcd_mod_counter #(
        .MIN_VAL(0), .MAX_VAL(23), .BLINK_PERIOD(8), .ZERO_BLANK(0)
    ) u_c (
        .clk(clk), .rst(rst), .tick(cout_w[0]), .modify(modify), .inc(inc), .dec(dec),
        .cout(cout_w[2]), .ones(ones_w[2]), .tens(tens_w[2]),
        .display0(d0_w[2]), .display1(d1_w[2])
    );

    // Model: value as a plain integer, age = cycles since entering set mode.
    int mn [3] = '{0, 1, 0};
    int mx [3] = '{59, 12, 23};
    int bp [3] = '{50_000_000, 8, 8};
    int zb [3] = '{0, 1, 0};
    int val [3];
    int age [3];
    bit pmod [3];
    bit model_valid = 1'b0;
    logic [7:0] segtab [10] = '{8'h03, 8'h9f, 8'h25, 8'h0d, 8'h99,
                                8'h49, 8'h41, 8'h1f, 8'h01, 8'h09};

    int n_cmp = 0;
    int n_err = 0;
    int ncout [3] = '{0, 0, 0};

    function automatic logic [7:0] seg(input int d);
        if (d < 0 || d > 9) return 8'hff;
        return segtab[d];
    endfunction

    function automatic bit m_cout(input int i, input bit t);
        return t && !modify && rst && (val[i] == mx[i]);
    endfunction

    task automatic chk(input string nm, input int i, input logic [7:0] act,
                       input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d] got %h want %h at %0t", nm, i, act, exp, $time);
        end
    endtask

    task automatic m_update(input int i, input bit t);
        if (!rst) begin
            val[i] = mn[i];
            age[i] = 0;
            pmod[i] = 1'b0;
        end else begin
            if (modify) begin
                age[i] = pmod[i] ? age[i] + 1 : 0;
                if (inc && !dec) val[i] = (val[i] == mx[i]) ? mn[i] : val[i] + 1;
                else if (dec && !inc) val[i] = (val[i] == mn[i]) ? mx[i] : val[i] - 1;
            end else begin
                age[i] = 0;
                if (t) val[i] = (val[i] == mx[i]) ? mn[i] : val[i] + 1;
            end
            pmod[i] = modify;
        end
    endtask

    always @(posedge clk) begin
        bit tc;
        tc = m_cout(0, tick);
        m_update(0, tick);
        m_update(1, tick);
        m_update(2, tc);
        model_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (model_valid) begin
            for (int i = 0; i < 3; i++) begin
                bit t, blank;
                logic [7:0] e0, e1;
                t = (i == 2) ? m_cout(0, tick) : tick;
                blank = (age[i] % bp[i]) >= (bp[i] / 2);
                e0 = blank ? 8'hff : seg(val[i] % 10);
                e1 = (blank || (zb[i] != 0 && val[i] / 10 == 0)) ? 8'hff : seg(val[i] / 10);
                chk("ones", i, {4'b0, ones_w[i]}, 8'(val[i] % 10));
                chk("tens", i, {4'b0, tens_w[i]}, 8'(val[i] / 10));
                chk("display0", i, d0_w[i], e0);
                chk("display1", i, d1_w[i], e1);
                chk("cout", i, {7'b0, cout_w[i]}, {7'b0, m_cout(i, t)});
                if (cout_w[i]) ncout[i]++;
            end
        end
    end

    task automatic step(input logic r, input logic t, input logic m, input logic i,
                        input logic d);
        rst = r; tick = t; modify = m; inc = i; dec = d;
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) step(1, 1, 0, 0, 0);
    endtask

    initial begin
        // Reset values
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("lit_rst_a_ones", 0, {4'b0, ones_w[0]}, 8'h00);
        chk("lit_rst_a_d0", 0, d0_w[0], 8'h03);
        chk("lit_rst_a_d1", 0, d1_w[0], 8'h03);
        chk("lit_rst_b_ones", 1, {4'b0, ones_w[1]}, 8'h01);
        chk("lit_rst_b_d0", 1, d0_w[1], 8'h9f);
        chk("lit_rst_b_d1", 1, d1_w[1], 8'hff);
        chk("lit_rst_cout", 0, {7'b0, cout_w[0]}, 8'h00);

        // 60 run-mode ticks
        ncout = '{0, 0, 0};
        ticks(11);
        chk("lit_b12_tens", 1, {4'b0, tens_w[1]}, 8'h01);
        chk("lit_b12_d1", 1, d1_w[1], 8'h9f);
        chk("lit_b12_d0", 1, d0_w[1], 8'h25);
        ticks(49);
        chk("lit_a_wrap_d0", 0, d0_w[0], 8'h03);
        chk("lit_a_wrap_d1", 0, d1_w[0], 8'h03);
        chk("lit_a_couts", 0, 8'(ncout[0]), 8'd1);
        chk("lit_b_couts", 1, 8'(ncout[1]), 8'd5);
        chk("lit_c_ones", 2, {4'b0, ones_w[2]}, 8'h01);

        // Set mode: entry, dec wrap, inc wrap, inc+dec, ignored ticks
        step(1, 0, 1, 0, 0);
        step(1, 0, 1, 0, 1);
        chk("lit_dec_ones", 0, {4'b0, ones_w[0]}, 8'h09);
        chk("lit_dec_tens", 0, {4'b0, tens_w[0]}, 8'h05);
        step(1, 0, 1, 1, 0);
        chk("lit_inc_ones", 0, {4'b0, ones_w[0]}, 8'h00);
        step(1, 0, 1, 1, 1);
        step(1, 1, 1, 0, 0);
        step(1, 1, 1, 0, 0);
        chk("lit_set_tick_b", 1, {4'b0, ones_w[1]}, 8'h01);
        for (int k = 0; k < 7; k++) step(1, 0, 1, 0, 0);
        chk("lit_blank_d0", 1, d0_w[1], 8'hff);
        chk("lit_blank_d1", 1, d1_w[1], 8'hff);
        step(1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0);
        chk("lit_reraise_d0", 1, d0_w[1], 8'h9f);
        for (int k = 0; k < 10; k++) step(1, 0, 1, 0, 0);

        // Reset during set mode at 37 with tick and inc high
        ticks(37);
        chk("lit_a37_tens", 0, {4'b0, tens_w[0]}, 8'h03);
        chk("lit_a37_ones", 0, {4'b0, ones_w[0]}, 8'h07);
        step(1, 0, 1, 0, 0);
        rst = 0; tick = 1; modify = 1; inc = 1; dec = 0;
        #1;
        chk("lit_rst_set_cout", 0, {7'b0, cout_w[0]}, 8'h00);
        @(posedge clk);
        #1;
        chk("lit_rst_set_ones", 0, {4'b0, ones_w[0]}, 8'h00);
        chk("lit_rst_set_tens", 0, {4'b0, tens_w[0]}, 8'h00);
        chk("lit_rst_set_b", 1, {4'b0, ones_w[1]}, 8'h01);

        // Chain: 1440 seconds wrap the 0-23 stage exactly once
        ncout = '{0, 0, 0};
        ticks(1440);
        chk("lit_chain_a_couts", 0, 8'(ncout[0]), 8'd24);
        chk("lit_chain_c_couts", 2, 8'(ncout[2]), 8'd1);
        chk("lit_chain_c_tens", 2, {4'b0, tens_w[2]}, 8'h00);
        chk("lit_chain_c_ones", 2, {4'b0, ones_w[2]}, 8'h00);

        // Reset masks carry even at MAX with tick in run mode
        ticks(59);
        rst = 0; tick = 1; modify = 0; inc = 0; dec = 0;
        #1;
        chk("lit_rst_max_cout", 0, {7'b0, cout_w[0]}, 8'h00);
        @(posedge clk);
        #1;
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
